// File: rtl/tone_pkg.sv
// ---------------------------------------------------------------------------
// tone_pkg
// Shared definitions for the buzzer tone generator:
//   tone_state_e    - controller state encoding (IDLE / RUN / GAP)
//   TONE_CNT_W      - default width of period / compare values
//   TONE_GAP_CYCLES - default articulation gap length in clk cycles
//   MIN_ARR         - smallest period value that produces a tone
//   gap_width()     - width of the articulation gap down-counter
// ---------------------------------------------------------------------------
package tone_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } tone_state_e;

  localparam int TONE_CNT_W      = 32;
  localparam int TONE_GAP_CYCLES = 500000;  // 10 ms at 50 MHz
  localparam int MIN_ARR         = 2;       // periods below this are silence

  // Counter width able to hold GAP_CYCLES-1, never less than one bit.
  function automatic int gap_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/tone_pwm_gen_if.sv
// ---------------------------------------------------------------------------
// tone_pwm_gen_if
// Connection between the song/note sequencer and the tone generator.
//   cnt_en       - run enable (sequencer -> generator)
//   counter_arr  - tone period in clk cycles (sequencer -> generator)
//   counter_ccr  - high time in clk cycles (sequencer -> generator)
//   note_strobe  - one-cycle beat boundary pulse (sequencer -> generator)
//   o_pwn        - registered buzzer drive (generator -> sequencer/pin)
//   period_done  - pulse on the last cycle of each active period
//   busy         - generator is playing or in an articulation gap
// Modports: master = sequencer side, slave = tone generator side.
// ---------------------------------------------------------------------------
interface tone_pwm_gen_if
  import tone_pkg::*;
#(
  parameter int CNT_W = TONE_CNT_W
);

  logic             cnt_en;
  logic [CNT_W-1:0] counter_arr;
  logic [CNT_W-1:0] counter_ccr;
  logic             note_strobe;
  logic             o_pwn;
  logic             period_done;
  logic             busy;

  modport master (
    output cnt_en, counter_arr, counter_ccr, note_strobe,
    input  o_pwn, period_done, busy
  );

  modport slave (
    input  cnt_en, counter_arr, counter_ccr, note_strobe,
    output o_pwn, period_done, busy
  );

endinterface

// File: rtl/tone_gap_timer.sv
// ---------------------------------------------------------------------------
// tone_gap_timer
// Down-counter timing the silent articulation gap between beats.
//   clk    - system clock
//   rst_n  - asynchronous active-low reset (count cleared to 0)
//   load   - restart the gap at GAP_CYCLES-1 (has priority over dec)
//   dec    - count down one step; holds at zero
//   done   - count is zero (the current cycle is the last gap cycle)
// ---------------------------------------------------------------------------
module tone_gap_timer
  import tone_pkg::*;
#(
  parameter int GAP_CYCLES = TONE_GAP_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int                 GAP_W    = gap_width(GAP_CYCLES);
  localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  logic [GAP_W-1:0] gap_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_reg <= '0;
    end else if (load) begin
      gap_cnt_reg <= GAP_LOAD;
    end else if (dec && (gap_cnt_reg != '0)) begin
      gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
    end
  end

  assign done = (gap_cnt_reg == '0);

endmodule

// File: rtl/tone_pwm_gen.sv
// ---------------------------------------------------------------------------
// tone_pwm_gen
// Square-wave tone generator for the passive buzzer. Period and compare
// values are double-buffered and only picked up at a period boundary, and
// every beat boundary (note_strobe) inserts a short silent gap.
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   bus    - tone_pwm_gen_if.slave: cnt_en, counter_arr, counter_ccr,
//            note_strobe in; o_pwn, period_done, busy out
// ---------------------------------------------------------------------------
module tone_pwm_gen
  import tone_pkg::*;
#(
  parameter int CNT_W      = TONE_CNT_W,
  parameter int GAP_CYCLES = TONE_GAP_CYCLES
) (
  input  logic           clk,
  input  logic           rst_n,
  tone_pwm_gen_if.slave  bus
);

  tone_state_e      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] arr_sh_reg;
  logic [CNT_W-1:0] ccr_sh_reg;
  logic             o_pwn_reg;

  logic             start_ok;
  logic             period_end;
  logic             gap_load;
  logic             gap_dec;
  logic             gap_done;

  // A period value below MIN_ARR means "no tone".
  assign start_ok = (bus.counter_arr >= CNT_W'(MIN_ARR));

  // arr_sh_reg is always >= MIN_ARR while in RUN, so the subtraction
  // cannot wrap when it matters.
  assign period_end = (cnt_reg == (arr_sh_reg - CNT_W'(1)));

  // A strobe in RUN starts the gap; a strobe in GAP restarts it.
  assign gap_load = bus.cnt_en && bus.note_strobe && (state_reg != IDLE);
  assign gap_dec  = bus.cnt_en && (state_reg == GAP);

  tone_gap_timer #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_gap_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (gap_load),
    .dec   (gap_dec),
    .done  (gap_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      arr_sh_reg <= '0;
      ccr_sh_reg <= '0;
      o_pwn_reg  <= 1'b0;
    end else if (!bus.cnt_en) begin
      // Frozen: state and counters hold, output is silenced.
      o_pwn_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          o_pwn_reg <= 1'b0;
          if (start_ok) begin
            arr_sh_reg <= bus.counter_arr;
            ccr_sh_reg <= bus.counter_ccr;
            cnt_reg    <= '0;
            state_reg  <= RUN;
          end
        end

        RUN: begin
          if (bus.note_strobe) begin
            cnt_reg   <= '0;
            o_pwn_reg <= 1'b0;
            state_reg <= GAP;
          end else begin
            // ccr >= arr gives 100% duty, ccr == 0 gives 0% duty.
            o_pwn_reg <= (cnt_reg < ccr_sh_reg);
            if (period_end) begin
              cnt_reg    <= '0;
              arr_sh_reg <= bus.counter_arr;
              ccr_sh_reg <= bus.counter_ccr;
              if (!start_ok) begin
                state_reg <= IDLE;
              end
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end

        GAP: begin
          o_pwn_reg <= 1'b0;
          // A strobe on the last gap cycle restarts the gap instead.
          if (!bus.note_strobe && gap_done) begin
            if (start_ok) begin
              arr_sh_reg <= bus.counter_arr;
              ccr_sh_reg <= bus.counter_ccr;
              cnt_reg    <= '0;
              state_reg  <= RUN;
            end else begin
              state_reg <= IDLE;
            end
          end
        end

        default: begin
          o_pwn_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Strobe wins over period end: no period_done on a cut-short period.
  assign bus.period_done = bus.cnt_en && (state_reg == RUN) &&
                           !bus.note_strobe && period_end;
  assign bus.busy        = (state_reg != IDLE);
  assign bus.o_pwn       = o_pwn_reg;

endmodule

// File: tb/tb_tone_pwm_gen.sv
// ---------------------------------------------------------------------------
// tb_tone_pwm_gen
// Self-checking bench for tone_pwm_gen (CNT_W=16, GAP_CYCLES=4).
// A tone-level reference model predicts o_pwn / period_done / busy on every
// cycle; a segment table and hand-written sequences add explicit checks.
// ---------------------------------------------------------------------------
module tb_tone_pwm_gen;

  localparam int CNT_W = 16;
  localparam int GAP   = 4;

  logic clk = 1'b0;
  logic rst_n;

  tone_pwm_gen_if #(.CNT_W(CNT_W)) bus ();

  tone_pwm_gen #(
    .CNT_W      (CNT_W),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // playing: a tone is sounding; silent_left >= 0: inside an articulation
  // gap with that many further gap cycles after the current one.
  bit m_playing;
  int silent_left;
  int tone_period, tone_high, tone_pos;
  bit m_out;

  task automatic m_reset();
    m_playing   = 0;
    silent_left = -1;
    tone_period = 0;
    tone_high   = 0;
    tone_pos    = 0;
    m_out       = 0;
  endtask

  function automatic bit m_busy();
    return m_playing || (silent_left >= 0);
  endfunction

  function automatic bit m_done();
    return bus.cnt_en && m_playing && !bus.note_strobe &&
           (tone_pos == tone_period - 1);
  endfunction

  task automatic m_begin_note();
    if (int'(bus.counter_arr) >= 2) begin
      m_playing   = 1;
      tone_period = int'(bus.counter_arr);
      tone_high   = int'(bus.counter_ccr);
      tone_pos    = 0;
    end
  endtask

  task automatic m_step();
    if (!rst_n) begin
      m_reset();
    end else if (!bus.cnt_en) begin
      m_out = 0;
    end else if (m_playing) begin
      if (bus.note_strobe) begin
        m_playing   = 0;
        silent_left = GAP - 1;
        tone_pos    = 0;
        m_out       = 0;
      end else begin
        m_out = (tone_pos < tone_high);
        if (tone_pos == tone_period - 1) begin
          m_playing = 0;
          m_begin_note();
        end else begin
          tone_pos++;
        end
      end
    end else if (silent_left >= 0) begin
      m_out = 0;
      if (bus.note_strobe) begin
        silent_left = GAP - 1;
      end else if (silent_left == 0) begin
        silent_left = -1;
        m_begin_note();
      end else begin
        silent_left--;
      end
    end else begin
      m_out = 0;
      m_begin_note();
    end
  endtask

  // One clock: sample and compare at the falling edge, advance the model,
  // return at rising edge + 1 so the caller can drive the next inputs.
  task automatic cycle(output bit pwn, output bit pd);
    @(negedge clk);
    pwn = bus.o_pwn;
    pd  = bus.period_done;
    chk("o_pwn", int'(bus.o_pwn), int'(m_out));
    chk("period_done", int'(bus.period_done), int'(m_done()));
    chk("busy", int'(bus.busy), int'(m_busy()));
    m_step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset between edges; outputs must clear at once.
  task automatic do_reset();
    bit p, d;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_o_pwn", int'(bus.o_pwn), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_period_done", int'(bus.period_done), 0);
    m_reset();
    cycle(p, d);
    rst_n = 1'b1;
  endtask

  task automatic set_in(input bit en, input int arr, input int ccr);
    bus.cnt_en      = en;
    bus.counter_arr = CNT_W'(arr);
    bus.counter_ccr = CNT_W'(ccr);
  endtask

  // ---------------- segment table ----------------
  typedef struct {
    bit en;
    int arr;
    int ccr;
    int ncyc;
    int exp_high;
    int exp_pd;
    bit exp_busy;
  } seg_t;

  seg_t segs[4];

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit p, d;
    int highs, pds, idx;

    rst_n           = 1'b0;
    bus.note_strobe = 1'b0;
    set_in(0, 0, 0);
    m_reset();

    segs[0] = '{1'b1, 10,  5, 24, 12, 2, 1'b1};  // basic 5/5 tone
    segs[1] = '{1'b1, 20, 15, 28, 18, 2, 1'b1};  // change at cnt=3
    segs[2] = '{1'b0, 20, 15,  5,  1, 0, 1'b1};  // freeze
    segs[3] = '{1'b1, 20, 15, 20, 14, 1, 1'b1};  // resume, no reload

    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle(p, d);
    chk("reset_state_busy", int'(bus.busy), 0);
    rst_n = 1'b1;

    for (int s = 0; s < 4; s++) begin
      set_in(segs[s].en, segs[s].arr, segs[s].ccr);
      highs = 0;
      pds   = 0;
      for (int c = 0; c < segs[s].ncyc; c++) begin
        cycle(p, d);
        highs += int'(p);
        pds   += int'(d);
      end
      chk("seg_high", highs, segs[s].exp_high);
      chk("seg_pd", pds, segs[s].exp_pd);
      chk("seg_busy", int'(bus.busy), int'(segs[s].exp_busy));
      $display("segment %0d: en=%0d arr=%0d ccr=%0d cycles=%0d high=%0d pd=%0d",
               s, segs[s].en, segs[s].arr, segs[s].ccr, segs[s].ncyc, highs, pds);
    end

    // Reset mid-run.
    do_reset();
    $display("reset mid-run applied");

    // Articulation gap: strobe in a high phase, then a restrike.
    set_in(1, 10, 5);
    for (int i = 0; i < 3; i++) cycle(p, d);
    bus.note_strobe = 1'b1;
    cycle(p, d);
    chk("strobe_in_high", int'(p), 1);
    bus.note_strobe = 1'b0;
    idx = 50;
    for (int i = 0; i < 50; i++) begin
      cycle(p, d);
      if (p) begin
        idx = i;
        break;
      end
    end
    chk("gap_low_cycles", idx, GAP + 1);
    $display("gap: low samples=%0d", idx);

    bus.note_strobe = 1'b1;
    cycle(p, d);
    bus.note_strobe = 1'b0;
    idx = 50;
    for (int i = 0; i < 50; i++) begin
      if (i == 1) bus.note_strobe = 1'b1;
      cycle(p, d);
      bus.note_strobe = 1'b0;
      if (p) begin
        idx = i;
        break;
      end
    end
    chk("gap_restrike_low", idx, 2 + GAP + 1);
    $display("gap restrike: low samples=%0d", idx);

    // Reset mid-gap, then the first period must be a full one.
    bus.note_strobe = 1'b1;
    cycle(p, d);
    bus.note_strobe = 1'b0;
    cycle(p, d);
    do_reset();
    set_in(1, 10, 5);
    idx = 40;
    for (int i = 0; i < 40; i++) begin
      cycle(p, d);
      if (d) begin
        idx = i;
        break;
      end
    end
    chk("first_period_after_reset", idx, 10);
    $display("reset mid-gap: first period_done at sample %0d", idx);

    // Silence and duty edge cases.
    do_reset();
    set_in(1, 1, 0);
    for (int i = 0; i < 5; i++) cycle(p, d);
    chk("arr1_stays_idle", int'(bus.busy), 0);
    set_in(1, 10, 12);
    highs = 0;
    for (int i = 0; i < 25; i++) begin
      cycle(p, d);
      if (i >= 2) highs += int'(p);
    end
    chk("ccr_gt_arr_high", highs, 23);
    set_in(1, 10, 0);
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(p, d);
      if (i >= 20) highs += int'(p);
    end
    chk("ccr0_low", highs, 0);
    set_in(1, 10, 5);
    for (int i = 0; i < 15; i++) cycle(p, d);
    set_in(1, 0, 5);
    for (int i = 0; i < 15; i++) cycle(p, d);
    chk("arr0_idle_busy", int'(bus.busy), 0);
    chk("arr0_idle_pwn", int'(bus.o_pwn), 0);
    $display("silence/duty edge cases done");

    // Enable freeze at cnt=6 for 7 cycles.
    do_reset();
    set_in(1, 10, 8);
    for (int i = 0; i < 7; i++) cycle(p, d);
    bus.cnt_en = 1'b0;
    highs = 0;
    pds   = 0;
    for (int i = 0; i < 7; i++) begin
      cycle(p, d);
      if (i >= 1) highs += int'(p);
      pds += int'(d);
    end
    chk("freeze_high", highs, 0);
    chk("freeze_pd", pds, 0);
    bus.cnt_en = 1'b1;
    idx = 40;
    for (int i = 0; i < 40; i++) begin
      cycle(p, d);
      if (d) begin
        idx = i;
        break;
      end
    end
    chk("resume_pd_index", idx, 3);
    $display("freeze: resume period_done at sample %0d", idx);

    // Randomized run against the model.
    do_reset();
    set_in(1, 8, 3);
    for (int i = 0; i < 1500; i++) begin
      bus.cnt_en      = ($urandom_range(15) != 0);
      bus.note_strobe = ($urandom_range(39) == 0);
      if ($urandom_range(19) == 0) begin
        bus.counter_arr = CNT_W'($urandom_range(12));
        bus.counter_ccr = CNT_W'($urandom_range(14));
      end
      cycle(p, d);
    end
    bus.note_strobe = 1'b0;
    $display("random: 1500 cycles compared against model");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_pwm_gen.md
Name: tone_pwm_gen

Overview:
Square-wave tone generator that drives the passive buzzer output. It consumes the period value (counter_arr) and compare value (counter_ccr) produced by the song/note sequencer, once per beat.
- Double-buffers both values so that a change only takes effect at a period boundary (no glitched half-periods).
- Inserts a short silent articulation gap on each beat boundary, so repeated identical notes are audibly separated.

Parameters:
CNT_W, 32, width of period/compare values and internal period counter
GAP_CYCLES, 500000, articulation gap length in clk cycles (10 ms at 50 MHz); must be >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cnt_en  in  1  run enable; low freezes all counters and forces o_pwn low
counter_arr  in  CNT_W  tone period in clk cycles; values < 2 mean silence
counter_ccr  in  CNT_W  high-time in clk cycles within the period
note_strobe  in  1  one-cycle pulse at each beat boundary from the sequencer
o_pwn  out  1  buzzer drive, registered
period_done  out  1  one-cycle pulse on the last cycle of each active period
busy  out  1  high in RUN or GAP

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; cnt, arr_sh, ccr_sh and gap_cnt = 0.
  - o_pwn=0, period_done=0, busy=0.
  - Reset mid-period or mid-gap aborts immediately; no partial period after release.
- cnt_en=0 in any state:
  - state, cnt and gap_cnt hold.
  - o_pwn<=0 and period_done=0.
  - note_strobe is ignored.
- IDLE:
  - If cnt_en and counter_arr>=2: load arr_sh<=counter_arr, ccr_sh<=counter_ccr, cnt<=0, go RUN.
  - Otherwise stay; o_pwn<=0.
- RUN, per enabled cycle:
  - o_pwn <= (cnt < ccr_sh).
  - If ccr_sh>=arr_sh, o_pwn is high for the whole period (100% duty).
  - If ccr_sh=0, o_pwn is always low.
- RUN, at period end (cnt==arr_sh-1):
  - period_done=1 that cycle.
  - cnt<=0, and the shadows reload from the inputs.
  - If the new counter_arr<2, go IDLE instead, with o_pwn<=0 from the next edge.
- RUN, otherwise: cnt<=cnt+1.
- Input changes mid-period have no effect until the period end.
- Latency: input presented in IDLE before edge N → load at edge N → o_pwn high after edge N+1 (if ccr>0).
- note_strobe in RUN (cnt_en=1):
  - Go GAP; gap_cnt<=GAP_CYCLES-1; cnt<=0; o_pwn<=0.
  - No period_done that cycle, even if it coincides with the period end.
- GAP:
  - o_pwn<=0; gap_cnt decrements each enabled cycle.
  - Another note_strobe in GAP restarts gap_cnt at GAP_CYCLES-1.
  - At gap_cnt==0: sample the inputs as in IDLE (load and go RUN if counter_arr>=2, else go IDLE).
- note_strobe in IDLE: ignored.
- Arithmetic: all compares are unsigned CNT_W-bit.
  - cnt never exceeds arr_sh-1, so there is no wrap-around.
  - gap_cnt is $clog2(GAP_CYCLES) bits wide (minimum 1).
- busy = (state != IDLE), combinational from state.

Decomposition:
- Package tone_pkg:
  - state encoding (IDLE=2'd0, RUN=2'd1, GAP=2'd2)
  - default CNT_W
  - GAP_CYCLES default
  - the MIN_ARR=2 silence threshold
- Sub-module tone_gap_timer:
  - load/decrement/done down-counter for the articulation gap.
  - Natural split; keeps the main FSM and period counter in tone_pwm_gen.

Test Plan:
1. Basic tone: arr=10, ccr=5, cnt_en=1 from IDLE → after latency o_pwn repeats 5 high / 5 low; period_done pulses every 10 cycles on the cnt==9 cycle.
2. Change arr to 20 and ccr to 15 at cnt=3 → the current 10-cycle period completes unchanged, then 15 high / 5 low periods follow.
3. Articulation gap (GAP_CYCLES=4): note_strobe during a high phase → o_pwn low on the next edge, stays low exactly 4 cycles, then a new period starts with the current inputs. A second note_strobe at gap cycle 2 extends the silence to 2+4 cycles.
4. Silence and edge cases:
   - arr=0 mid-run → finish the period, then IDLE with o_pwn=0 and busy=0.
   - arr=1 from IDLE → stays IDLE.
   - ccr=12 with arr=10 → o_pwn constantly high.
   - ccr=0 → o_pwn constantly low.
5. Enable freeze: drop cnt_en at cnt=6 for 7 cycles → o_pwn=0 and no period_done while low; on re-enable, counting resumes from cnt=6 with no extra load.
6. Reset mid-gap and mid-run: assert rst_n low asynchronously between clk edges → o_pwn, busy and period_done are 0 immediately. After release with arr=10, the first period is a full 10 cycles.
